// File: rtl/uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_pkg
//   Shared constants for the configurable UART transmitter:
//   - FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   - parity-type selector values (PAR_EVEN, PAR_ODD)
//   - serial line levels (LINE_IDLE, START_BIT)
//   - parity_of(): parity bit for a word given the parity type
// ---------------------------------------------------------------------------
package uart_tx_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] START  = 3'd1;
    localparam logic [STATE_W-1:0] DATA   = 3'd2;
    localparam logic [STATE_W-1:0] PARITY = 3'd3;
    localparam logic [STATE_W-1:0] STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

    // Words narrower than 9 bits are zero-extended by the caller; the extra
    // zeros do not change the XOR reduction.
    function automatic logic parity_of(input logic [8:0] d, input logic par_type);
        logic p;
        p = ^d;
        case (par_type)
            PAR_EVEN: parity_of = p;
            PAR_ODD:  parity_of = ~p;
            default:  parity_of = p;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg_if
//   Word-input side of the UART transmitter.
//   P_Data      word to send (LSB first on the line)
//   Data_Valid  source has a word plus configuration on the bus
//   Data_Ready  transmitter can take the word this cycle
//   Par_En      insert a parity bit after the data bits
//   Par_Type    0 = even, 1 = odd parity
//   Stop_Two    0 = one stop bit, 1 = two stop bits
//   Prescale    clocks per bit (0 behaves as 1)
//
//   Handshake: a word is transferred on a rising edge where Data_Valid and
//   Data_Ready are both high. The source holds P_Data and all configuration
//   stable while Data_Valid is high and not yet accepted. Data_Ready may be
//   evaluated independently of Data_Valid; Data_Valid while Data_Ready is low
//   is simply ignored.
// ---------------------------------------------------------------------------
interface uart_tx_cfg_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 16
);
    logic [DATA_WIDTH-1:0] P_Data;
    logic                  Data_Valid;
    logic                  Data_Ready;
    logic                  Par_En;
    logic                  Par_Type;
    logic                  Stop_Two;
    logic [PRESCALE_W-1:0] Prescale;

    modport master (
        output P_Data, Data_Valid, Par_En, Par_Type, Stop_Two, Prescale,
        input  Data_Ready
    );

    modport slave (
        input  P_Data, Data_Valid, Par_En, Par_Type, Stop_Two, Prescale,
        output Data_Ready
    );
endinterface

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
//   Bit-time counter. Counts 0..prescale-1 while enabled and raises tick
//   combinationally for the single cycle in which the count is prescale-1.
//   clk       system clock
//   RST       synchronous active-high reset
//   enable    count while a frame is in progress
//   load      restart the count at zero (frame start)
//   prescale  clocks per bit, must be >= 1
//   tick      last clock of the current bit
// ---------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  enable,
    input  logic                  load,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] count;

    assign tick = enable && (count == prescale - PRESCALE_W'(1));

    always_ff @(posedge clk) begin
        if (RST) begin
            count <= '0;
        end else if (load || !enable || tick) begin
            count <= '0;
        end else begin
            count <= count + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg
//   Runtime-configurable UART transmitter. Frame: start bit, DATA_WIDTH data
//   bits LSB first, optional parity bit, one or two stop bits; every bit is
//   held for the latched prescale count of clocks. A new word can be taken on
//   the final clock of the last stop bit, so back-to-back frames have no gap.
//   clk        system clock, rising edge
//   RST        synchronous active-high reset
//   bus        word input handshake and per-frame configuration (slave side)
//   TX_Out     registered serial line, idle high
//   Busy       registered, high while a frame is on the line
//   state_dbg  current FSM state (uart_tx_pkg encoding)
// ---------------------------------------------------------------------------
module uart_tx_cfg
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 16
) (
    input  logic               clk,
    input  logic               RST,
    uart_tx_cfg_if.slave       bus,
    output logic               TX_Out,
    output logic               Busy,
    output logic [STATE_W-1:0] state_dbg
);

    localparam int BIT_W = $clog2(DATA_WIDTH);

    logic [STATE_W-1:0]    state, state_n;
    logic                  tx_q, tx_n;
    logic                  busy_q;
    logic [BIT_W-1:0]      bit_cnt, bit_n;

    // Per-frame copies of the configuration, frozen at accept time.
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  stop_two_q;
    logic [PRESCALE_W-1:0] prescale_q;

    logic tick;
    logic accept;
    logic last_data;
    logic last_stop;

    uart_baud_tick #(
        .PRESCALE_W (PRESCALE_W)
    ) u_baud_tick (
        .clk      (clk),
        .RST      (RST),
        .enable   (state != IDLE),
        .load     (accept),
        .prescale (prescale_q),
        .tick     (tick)
    );

    assign last_data = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
    assign last_stop = (bit_cnt == BIT_W'(stop_two_q));

    // Ready in IDLE, and also on the very last clock of the final stop bit so
    // the next start bit follows with no idle gap.
    assign bus.Data_Ready = !RST && ((state == IDLE) ||
                                     ((state == STOP) && last_stop && tick));
    assign accept = bus.Data_Valid && bus.Data_Ready;

    // TX_Out is registered from the next-state decision, so the line level
    // changes on the same edge as the state.
    always_comb begin
        state_n = state;
        tx_n    = tx_q;
        bit_n   = bit_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = START;
                    tx_n    = START_BIT;
                    bit_n   = '0;
                end
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                    tx_n    = data_q[0];
                    bit_n   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (last_data) begin
                        bit_n = '0;
                        if (par_en_q) begin
                            state_n = PARITY;
                            tx_n    = par_bit_q;
                        end else begin
                            state_n = STOP;
                            tx_n    = LINE_IDLE;
                        end
                    end else begin
                        // data_q shifts right on this same edge, so bit 1 of
                        // the current copy is the next bit to send.
                        bit_n = bit_cnt + BIT_W'(1);
                        tx_n  = data_q[1];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_n = STOP;
                    tx_n    = LINE_IDLE;
                    bit_n   = '0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (last_stop) begin
                        bit_n = '0;
                        if (accept) begin
                            state_n = START;
                            tx_n    = START_BIT;
                        end else begin
                            state_n = IDLE;
                            tx_n    = LINE_IDLE;
                        end
                    end else begin
                        bit_n = bit_cnt + BIT_W'(1);
                        tx_n  = LINE_IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = LINE_IDLE;
                bit_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state      <= IDLE;
            tx_q       <= LINE_IDLE;
            busy_q     <= 1'b0;
            bit_cnt    <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop_two_q <= 1'b0;
            prescale_q <= PRESCALE_W'(1);
        end else begin
            state   <= state_n;
            tx_q    <= tx_n;
            busy_q  <= (state_n != IDLE);
            bit_cnt <= bit_n;
            if (accept) begin
                data_q     <= bus.P_Data;
                par_en_q   <= bus.Par_En;
                par_bit_q  <= parity_of(9'(bus.P_Data), bus.Par_Type);
                stop_two_q <= bus.Stop_Two;
                prescale_q <= (bus.Prescale == '0) ? PRESCALE_W'(1) : bus.Prescale;
            end else if ((state == DATA) && tick) begin
                data_q <= data_q >> 1;
            end
        end
    end

    assign TX_Out    = tx_q;
    assign Busy      = busy_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_cfg
//   Self-checking bench for uart_tx_cfg (DATA_WIDTH=8). A frame model expands
//   every accepted word into a per-clock queue of expected line levels; a
//   compare process checks TX_Out, Busy and Data_Ready each cycle. Directed
//   tests add literal checks of frame length and selected bit values.
// ---------------------------------------------------------------------------
module tb_uart_tx_cfg;

    localparam int DW = 8;
    localparam int PW = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_cfg_if #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) bus ();

    logic       tx_out;
    logic       busy;
    logic [2:0] state_dbg;

    uart_tx_cfg #(
        .DATA_WIDTH (DW),
        .PRESCALE_W (PW)
    ) dut (
        .clk       (clk),
        .RST       (rst),
        .bus       (bus),
        .TX_Out    (tx_out),
        .Busy      (busy),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int   vectors = 0;
    int   miscompares = 0;
    logic [0:0] exp_q[$];
    bit   armed = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame as a sequence of bit levels, index 0 sent first.
    function automatic logic [15:0] build_bits(input logic [DW-1:0] d, input logic pe,
                                               input logic pt, input logic st,
                                               output int len);
        logic [15:0] b;
        int ones;
        b    = '0;
        ones = 0;
        len  = 0;
        b[len] = 1'b0; len++;
        for (int i = 0; i < DW; i++) begin
            b[len] = d[i]; len++;
            if (d[i]) ones++;
        end
        if (pe) begin
            // Even: total ones including parity is even. Odd: total is odd.
            b[len] = pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
            len++;
        end
        b[len] = 1'b1; len++;
        if (st) begin
            b[len] = 1'b1; len++;
        end
        return b;
    endfunction

    task automatic push_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                              input logic st, input logic [PW-1:0] ps);
        logic [15:0] b;
        int len;
        int p;
        p = (ps == 0) ? 1 : int'(ps);
        b = build_bits(d, pe, pt, st, len);
        for (int i = 0; i < len; i++)
            for (int j = 0; j < p; j++)
                exp_q.push_back(b[i]);
    endtask

    // One compare per cycle, away from the active edge.
    always @(negedge clk) begin
        logic exp_tx;
        logic exp_busy;
        logic exp_ready;
        if (armed) begin
            exp_tx    = (exp_q.size() != 0) ? exp_q[0] : 1'b1;
            exp_busy  = (exp_q.size() != 0);
            exp_ready = !rst && (exp_q.size() <= 1);
            check("tx_out", tx_out, exp_tx);
            check("busy", busy, exp_busy);
            check("data_ready", bus.Data_Ready, exp_ready);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (rst) exp_q.delete();
            else if (bus.Data_Valid && exp_ready)
                push_frame(bus.P_Data, bus.Par_En, bus.Par_Type, bus.Stop_Two, bus.Prescale);
        end
        if (rst) armed = 1'b1;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_accept();
        int n = 0;
        while (n < 500) begin
            @(negedge clk);
            n++;
            if (bus.Data_Ready) break;
        end
        if (!bus.Data_Ready) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: no Data_Ready within %0d cycles", n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic pe, input logic pt,
                             input logic st, input logic [PW-1:0] ps);
        @(posedge clk);
        #1;
        bus.P_Data     = d;
        bus.Par_En     = pe;
        bus.Par_Type   = pt;
        bus.Stop_Two   = st;
        bus.Prescale   = ps;
        bus.Data_Valid = 1'b1;
        wait_accept();
        bus.Data_Valid = 1'b0;
    endtask

    // Counts Busy cycles until the line goes idle; records TX_Out on cycle
    // probe_k (1 = first cycle after the accept edge). Drops Data_Valid after
    // any further accept seen along the way.
    task automatic run_until_idle(input int probe_k, output int busy_cnt, output logic probe_val);
        int  k = 0;
        bit  done = 1'b0;
        busy_cnt  = 0;
        probe_val = 1'bx;
        while (!done) begin
            @(negedge clk);
            k++;
            if (k == probe_k) probe_val = tx_out;
            if (!busy) begin
                done = 1'b1;
            end else if (k > 500) begin
                vectors++;
                miscompares++;
                $display("FAIL idle_timeout: Busy still high after %0d cycles", k);
                done = 1'b1;
            end else begin
                busy_cnt++;
                if (bus.Data_Valid && bus.Data_Ready) begin
                    @(posedge clk);
                    #1;
                    bus.Data_Valid = 1'b0;
                end
            end
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int          cnt;
        logic        pv;
        int          len;
        logic [15:0] b;

        bus.P_Data     = '0;
        bus.Data_Valid = 1'b0;
        bus.Par_En     = 1'b0;
        bus.Par_Type   = 1'b0;
        bus.Stop_Two   = 1'b0;
        bus.Prescale   = '0;
        rst            = 1'b1;

        // Pin the frame model against hand-derived bit sequences.
        b = build_bits(8'hA5, 1'b0, 1'b0, 1'b0, len);
        check("model_a5_len", len, 10);
        check("model_a5_bits", b[9:0], 10'b1101001010);
        b = build_bits(8'h07, 1'b1, 1'b0, 1'b0, len);
        check("model_par_even", b[9], 1'b1);
        b = build_bits(8'h07, 1'b1, 1'b1, 1'b0, len);
        check("model_par_odd", b[9], 1'b0);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_tx", tx_out, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_state", state_dbg, uart_tx_pkg::IDLE);
        check("reset_ready", bus.Data_Ready, 1'b1);

        // 1: 0xA5, P=4, no parity, one stop.
        send_word(8'hA5, 1'b0, 1'b0, 1'b0, 16'd4);
        run_until_idle(5, cnt, pv);
        check("t1_busy_cycles", cnt, 40);
        check("t1_bit0", pv, 1'b1);

        // 2: 0x07, P=2, parity even then odd; parity bit on cycles 19-20.
        send_word(8'h07, 1'b1, 1'b0, 1'b0, 16'd2);
        run_until_idle(19, cnt, pv);
        check("t2_even_cycles", cnt, 22);
        check("t2_even_parity", pv, 1'b1);
        send_word(8'h07, 1'b1, 1'b1, 1'b0, 16'd2);
        run_until_idle(19, cnt, pv);
        check("t2_odd_cycles", cnt, 22);
        check("t2_odd_parity", pv, 1'b0);

        // 3: 0x00, P=1, two stop bits.
        send_word(8'h00, 1'b0, 1'b0, 1'b1, 16'd1);
        run_until_idle(11, cnt, pv);
        check("t3_cycles", cnt, 11);
        check("t3_second_stop", pv, 1'b1);

        // 4: back-to-back 0x55 then 0xAA, P=3; second start on cycle 31.
        @(posedge clk);
        #1;
        bus.P_Data     = 8'h55;
        bus.Par_En     = 1'b0;
        bus.Par_Type   = 1'b0;
        bus.Stop_Two   = 1'b0;
        bus.Prescale   = 16'd3;
        bus.Data_Valid = 1'b1;
        wait_accept();
        bus.P_Data = 8'hAA;
        run_until_idle(31, cnt, pv);
        check("t4_total_cycles", cnt, 60);
        check("t4_second_start", pv, 1'b0);

        // 5: reset during data bit 3 of 0xFF (P=2, cycles 9-10).
        send_word(8'hFF, 1'b0, 1'b0, 1'b0, 16'd2);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_abort_tx", tx_out, 1'b1);
        check("t5_abort_busy", busy, 1'b0);
        check("t5_abort_state", state_dbg, uart_tx_pkg::IDLE);
        check("t5_ready", bus.Data_Ready, 1'b1);
        send_word(8'hFF, 1'b0, 1'b0, 1'b0, 16'd2);
        run_until_idle(9, cnt, pv);
        check("t5_refill_cycles", cnt, 20);
        check("t5_refill_bit3", pv, 1'b1);

        // 6: Prescale=0 behaves as 1; 0x3C has four ones, odd parity -> 1.
        send_word(8'h3C, 1'b1, 1'b1, 1'b0, 16'd0);
        run_until_idle(10, cnt, pv);
        check("t6_p0_cycles", cnt, 11);
        check("t6_p0_parity", pv, 1'b1);
        // Configuration changes mid-frame must not disturb the frame.
        send_word(8'h96, 1'b0, 1'b0, 1'b0, 16'd2);
        bus.Prescale = 16'd8;
        bus.P_Data   = 8'h00;
        bus.Par_En   = 1'b1;
        bus.Stop_Two = 1'b1;
        run_until_idle(5, cnt, pv);
        check("t6_mid_cycles", cnt, 20);
        check("t6_mid_bit1", pv, 1'b1);
        send_word(8'h01, 1'b0, 1'b0, 1'b0, 16'd8);
        run_until_idle(9, cnt, pv);
        check("t6_p8_cycles", cnt, 80);
        check("t6_p8_bit0", pv, 1'b1);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
